mr_rob: RTL

//  Parametrised in-order reorder/retire buffer. Successor to the single-slot writeback tracker.

---
 rtl/mr_rob.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mr_rob.sv
// mr_rob: in-order reorder/retire buffer between dispatch and the regfile.
//   Allocates entry IDs in program order, accepts out-of-order completions,
//   commits at most one entry per cycle from the head, and raises a one-cycle
//   pipe flush when a mispredicted branch/jump commits.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   alloc_*         dispatch handshake; alloc_id is the ID granted (= tail)
//   cpl_*           execution completion for entry cpl_id
//   is_speculating  some valid, uncompleted branch is in flight
//   reg_wb_*        regfile writeback of the committing entry
//   flush_valid/pc  one-cycle flush pulse and restart PC
//
// Optional feature: define MR_ROB_PERF_EN to add the free-running 32-bit
//   counters perf_commits and perf_flushes as extra output ports.
module mr_rob #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ID_BITS     = $clog2(DEPTH),
  parameter int unsigned REGSEL_BITS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [XLEN-1:0]        alloc_pc,
  input  logic                   alloc_is_br,
  output logic [ID_BITS-1:0]     alloc_id,
  input  logic                   cpl_valid,
  input  logic [ID_BITS-1:0]     cpl_id,
  input  logic [REGSEL_BITS-1:0] cpl_dst,
  input  logic [XLEN-1:0]        cpl_data,
  input  logic                   cpl_is_jump,
  input  logic                   cpl_taken,
  input  logic                   cpl_predicted,
  output logic                   is_speculating,
  output logic                   reg_wb_valid,
  output logic [REGSEL_BITS-1:0] reg_wb_dst,
  output logic [XLEN-1:0]        reg_wb_data,
  output logic                   flush_valid,
  output logic [XLEN-1:0]        flush_pc
`ifdef MR_ROB_PERF_EN
  ,
  output logic [31:0]            perf_commits,
  output logic [31:0]            perf_flushes
`endif
);

  localparam int unsigned CNT_BITS = ID_BITS + 1;
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

  typedef struct packed {
    logic                   valid;
    logic                   done;
    logic                   is_br;
    logic [XLEN-1:0]        pc;
    logic [REGSEL_BITS-1:0] dst;
    logic [XLEN-1:0]        data;
    logic                   is_jump;
    logic                   taken;
    logic                   mispredict;
  } entry_t;

  entry_t              rob [DEPTH];
  logic [ID_BITS-1:0]  head;
  logic [ID_BITS-1:0]  tail;
  logic [CNT_BITS-1:0] count;

  entry_t          head_e;
  logic [XLEN-1:0] head_pc4;
  logic            commit;
  logic            flush_pending;
  logic            alloc_fire;
  logic            cpl_fire;
  logic            spec_c;

  // Commit decision is purely from registered state at the head.
  assign head_e        = rob[head];
  assign head_pc4      = XLEN'(head_e.pc + XLEN'(4));
  assign commit        = head_e.valid & head_e.done;
  assign flush_pending = commit & head_e.mispredict;

  assign alloc_ready = (count != FULL_CNT) & ~flush_valid & ~flush_pending;
  assign alloc_id    = tail;
  assign alloc_fire  = alloc_valid & alloc_ready;

  // Completions to dropped entries, or during a flush, are discarded.
  assign cpl_fire = cpl_valid & rob[cpl_id].valid & ~flush_pending & ~flush_valid;

  assign reg_wb_valid = commit & (head_e.dst != '0);
  assign reg_wb_dst   = head_e.dst;
  assign reg_wb_data  = head_e.is_jump ? head_pc4 : head_e.data;

  // Any in-flight unresolved branch keeps downstream speculative.
  always_comb begin
    spec_c = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      spec_c = spec_c | (rob[ID_BITS'(i)].valid & rob[ID_BITS'(i)].is_br &
                         ~rob[ID_BITS'(i)].done);
    end
  end
  assign is_speculating = spec_c;

  // Entry array, pointers, occupancy and flush pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rob[ID_BITS'(i)] <= '0;
      end
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      flush_valid <= 1'b0;
      flush_pc    <= '0;
    end else begin
      flush_valid <= flush_pending;
      if (flush_pending) begin
        flush_pc <= head_e.taken ? head_e.data : head_pc4;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          rob[ID_BITS'(i)].valid <= 1'b0;
          rob[ID_BITS'(i)].done  <= 1'b0;
        end
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (cpl_fire) begin
          rob[cpl_id].done       <= 1'b1;
          rob[cpl_id].dst        <= cpl_dst;
          rob[cpl_id].data       <= cpl_data;
          rob[cpl_id].is_jump    <= cpl_is_jump;
          rob[cpl_id].taken      <= cpl_taken;
          rob[cpl_id].mispredict <= cpl_taken ^ cpl_predicted;
        end
        if (alloc_fire) begin
          rob[tail].valid <= 1'b1;
          rob[tail].done  <= 1'b0;
          rob[tail].is_br <= alloc_is_br;
          rob[tail].pc    <= alloc_pc;
          tail            <= ID_BITS'(tail + ID_BITS'(1));
        end
        // Placed last so a stray re-completion of the head cannot revive it.
        if (commit) begin
          rob[head].valid <= 1'b0;
          rob[head].done  <= 1'b0;
          head            <= ID_BITS'(head + ID_BITS'(1));
        end
        case ({alloc_fire, commit})
          2'b10:   count <= CNT_BITS'(count + CNT_BITS'(1));
          2'b01:   count <= CNT_BITS'(count - CNT_BITS'(1));
          default: count <= count;
        endcase
      end
    end
  end

`ifdef MR_ROB_PERF_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_commits <= '0;
      perf_flushes <= '0;
    end else begin
      if (commit) begin
        perf_commits <= perf_commits + 32'd1;
      end
      if (flush_valid) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`endif

endmodule
